sccb_write_arbiter: RTL and testbench
=====================================

// Module: sccb_write_arbiter
// PURPOSE
//  Shares the single SCCB write interface between NUM_REQ requesters (boot-time
//  OV7670 table sequencer, runtime exposure/gain tweaker, debug port). Round-robin
//  grant, latches one {reg addr, data} write per grant, sequences the SCCB
//  start/ready handshake, returns a done/err pulse to the granted requester.
//  Sits between the config sequencers and SCCB_interface in the camera config top.
// PARAMETERS
//  NUM_REQ         2       number of requesters, 2..4
//  SETTLE_CYCLES   16      idle gap after each write before next grant, >=1
//  TIMEOUT_CYCLES  65535   max cycles in any wait state before abort, >=4
// PORTS
//  clk          in   1          system clock (25 MHz camera domain)
//  rst          in   1          async, active-high reset
//  req          in   NUM_REQ    per-requester write request, level, held until done
//  req_addr     in   8*NUM_REQ  register addr, requester i at [8i+7:8i]
//  req_data     in   8*NUM_REQ  register data, same packing
//  grant        out  NUM_REQ    one-hot, high from ISSUE through end of WAIT_DONE
//  done         out  NUM_REQ    1-cycle pulse to granted requester, write finished
//  err          out  NUM_REQ    1-cycle pulse, coincident with done, on timeout
//  busy         out  1          high in any state except IDLE
//  sccb_start   out  1          1-cycle start pulse to SCCB_interface
//  sccb_addr    out  8          latched register address
//  sccb_data    out  8          latched register data
//  sccb_ready   in   1          SCCB_interface idle/complete flag
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer = 0, timer = 0.
//  FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, SETTLE.
//  IDLE: if |req and sccb_ready: pick first set req index at or after rr_ptr
//   (wrapping NUM_REQ-1 -> 0), latch its addr/data into sccb_addr/sccb_data,
//   set grant, -> ISSUE. Cycle N req sampled => cycle N+1 sccb_start=1.
//   If sccb_ready=0 remain IDLE, no grant.
//  ISSUE: sccb_start=1 exactly this cycle; timer cleared; -> WAIT_BUSY.
//  WAIT_BUSY: wait sccb_ready=0 (write accepted) -> WAIT_DONE, timer cleared.
//  WAIT_DONE: wait sccb_ready=1 -> pulse done[g]; -> SETTLE.
//  Timeout: timer increments each cycle in WAIT_BUSY/WAIT_DONE; reaching
//   TIMEOUT_CYCLES-1 -> pulse done[g] and err[g] together, -> SETTLE.
//  SETTLE: grant=0, count SETTLE_CYCLES cycles, rr_ptr = g+1 (mod NUM_REQ),
//   -> IDLE. Requester sees done then must drop or re-present req; a req still
//   high in IDLE is a new write (fair: others with req get served first).
//  sccb_addr/sccb_data stable from ISSUE until next grant; req/addr/data changes
//   after grant are ignored. Requester dropping req mid-write: write completes,
//   done still pulses.
//  Simultaneous req: rr order only; no priority. Max wait for any requester =
//   (NUM_REQ-1) full transactions.
//  done/err never asserted outside the granted bit; grant always one-hot or 0.
//  Reset mid-operation: immediate return to IDLE, sccb_start=0, no done/err;
//   in-flight SCCB write outcome is undefined, requesters must re-request.
// TESTING
//  1 req=01, addr0=0x12 data0=0x80, ready model drops 2 cyc after start, rises
//    40 cyc later -> start 1 cyc after req, sccb_addr=0x12/data=0x80, done[0]
//    on cycle ready rises, err=0, next grant >=16 cyc later.
//  2 req=11 held continuously, 4 writes -> grant order 0,1,0,1; never one-hot
//    violation; each done pulse single-cycle.
//  3 sccb_ready=0 at req -> no start until ready=1; then normal write.
//  4 TIMEOUT_CYCLES=32, ready never drops after start -> done[g]=err[g]=1 at
//    32 cycles after ISSUE, then SETTLE, next request served normally.
//  5 rst=1 during WAIT_DONE -> all outputs 0 same cycle asynchronously, no done;
//    after release req re-presented -> fresh write from IDLE.
//  6 NUM_REQ=3, req=101 with rr_ptr=1 -> requester 2 granted first, then 0.

Source files
------------

// File: rtl/sccb_write_arbiter.sv
// Round-robin arbiter that shares the single SCCB register-write port between
// the camera config requesters. One {addr, data} write is latched per grant and
// carried through the SCCB start/ready handshake. A done pulse, with err on
// timeout, goes back to the granted requester.
module sccb_write_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic [NUM_REQ-1:0]   err,
    output logic                 busy,
    output logic                 sccb_start,
    output logic [7:0]           sccb_addr,
    output logic [7:0]           sccb_data,
    input  logic                 sccb_ready
);

    localparam int unsigned PTR_W   = $clog2(NUM_REQ);
    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // Timer value from which the next increment reaches TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST     = PTR_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        SETTLE
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [CNT_W-1:0]   timer;

    logic               pick_vld_c;
    logic               hi_vld_c;
    logic [PTR_W-1:0]   hi_idx_c;
    logic [PTR_W-1:0]   lo_idx_c;
    logic [PTR_W-1:0]   pick_idx_c;
    logic [NUM_REQ-1:0] pick_oh_c;
    logic [7:0]         pick_addr_c;
    logic [7:0]         pick_data_c;
    logic [PTR_W-1:0]   rr_next_c;
    logic               timeout_c;

    // Round-robin pick: lowest requester at/after rr_ptr, else lowest overall (wrap).
    always_comb begin
        pick_vld_c  = 1'b0;
        hi_vld_c    = 1'b0;
        hi_idx_c    = '0;
        lo_idx_c    = '0;
        pick_idx_c  = '0;
        pick_oh_c   = '0;
        pick_addr_c = '0;
        pick_data_c = '0;
        for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
            if (req[j]) begin
                pick_vld_c = 1'b1;
                lo_idx_c   = PTR_W'(j);
                if (PTR_W'(j) >= rr_ptr) begin
                    hi_vld_c = 1'b1;
                    hi_idx_c = PTR_W'(j);
                end
            end
        end
        pick_idx_c = hi_vld_c ? hi_idx_c : lo_idx_c;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (PTR_W'(j) == pick_idx_c) begin
                pick_oh_c[j] = 1'b1;
                pick_addr_c  = req_addr[8*j +: 8];
                pick_data_c  = req_data[8*j +: 8];
            end
        end
    end

    // Pointer moves past the requester just served; timeout compare on the shared timer.
    always_comb begin
        rr_next_c = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + PTR_W'(1);
        timeout_c = (timer == TIMEOUT_LAST);
    end

    // Arbitration / handshake FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gnt_idx    <= '0;
            timer      <= '0;
            grant      <= '0;
            done       <= '0;
            err        <= '0;
            busy       <= 1'b0;
            sccb_start <= 1'b0;
            sccb_addr  <= '0;
            sccb_data  <= '0;
        end else begin
            done       <= '0;
            err        <= '0;
            sccb_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld_c && sccb_ready) begin
                        grant      <= pick_oh_c;
                        gnt_idx    <= pick_idx_c;
                        sccb_addr  <= pick_addr_c;
                        sccb_data  <= pick_data_c;
                        sccb_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!sccb_ready) begin
                        timer <= '0;
                        state <= WAIT_DONE;
                    end else if (timeout_c) begin
                        done   <= grant;
                        err    <= grant;
                        grant  <= '0;
                        rr_ptr <= rr_next_c;
                        timer  <= '0;
                        state  <= SETTLE;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (sccb_ready) begin
                        done   <= grant;
                        grant  <= '0;
                        rr_ptr <= rr_next_c;
                        timer  <= '0;
                        state  <= SETTLE;
                    end else if (timeout_c) begin
                        done   <= grant;
                        err    <= grant;
                        grant  <= '0;
                        rr_ptr <= rr_next_c;
                        timer  <= '0;
                        state  <= SETTLE;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (timer == SETTLE_LAST) begin
                        timer <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    timer <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_write_arbiter.sv
// Bench for sccb_write_arbiter: a 2-requester instance with default timing
// and a 3-requester instance with short settle and a 32-cycle timeout.
module tb_sccb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    // instance A: NUM_REQ=2, defaults
    logic [1:0]  req_a;
    logic [15:0] req_addr_a, req_data_a;
    logic [1:0]  grant_a, done_a, err_a;
    logic        busy_a, sccb_start_a, ready_a;
    logic [7:0]  sccb_addr_a, sccb_data_a;

    // instance B: NUM_REQ=3, SETTLE=4, TIMEOUT=32
    logic [2:0]  req_b;
    logic [23:0] req_addr_b, req_data_b;
    logic [2:0]  grant_b, done_b, err_b;
    logic        busy_b, sccb_start_b, ready_b;
    logic [7:0]  sccb_addr_b, sccb_data_b;

    // SCCB ready model controls
    logic        hold_a = 1'b0;
    logic        no_drop_b = 1'b0;
    int          rise_cyc_a = 0;

    typedef struct packed {
        logic [1:0] g;
        logic [7:0] a;
        logic [7:0] d;
        logic       e;
    } exp_t;
    exp_t q_a[$];
    exp_t cur_a;

    typedef struct {
        logic [1:0] req;
        logic [7:0] a0, d0, a1, d1;
        int         idx;
    } vec_t;
    vec_t tbl[8];

    localparam int SIG_START_A = 0, SIG_DONE_A = 1, SIG_IDLE_A = 2;
    localparam int SIG_START_B = 3, SIG_DONE_B = 4, SIG_IDLE_B = 5;

    sccb_write_arbiter u_dut_a (
        .clk(clk), .rst(rst), .req(req_a), .req_addr(req_addr_a), .req_data(req_data_a),
        .grant(grant_a), .done(done_a), .err(err_a), .busy(busy_a),
        .sccb_start(sccb_start_a), .sccb_addr(sccb_addr_a), .sccb_data(sccb_data_a),
        .sccb_ready(ready_a)
    );

    sccb_write_arbiter #(.NUM_REQ(3), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(32)) u_dut_b (
        .clk(clk), .rst(rst), .req(req_b), .req_addr(req_addr_b), .req_data(req_data_b),
        .grant(grant_b), .done(done_b), .err(err_b), .busy(busy_b),
        .sccb_start(sccb_start_b), .sccb_addr(sccb_addr_b), .sccb_data(sccb_data_b),
        .sccb_ready(ready_b)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit sig_now(input int sig);
        case (sig)
            SIG_START_A: return sccb_start_a;
            SIG_DONE_A:  return |done_a;
            SIG_IDLE_A:  return !busy_a;
            SIG_START_B: return sccb_start_b;
            SIG_DONE_B:  return |done_b;
            SIG_IDLE_B:  return !busy_b;
            default:     return 1'b0;
        endcase
    endfunction

    // Bounded wait on a DUT event, sampled at negedge; expiry counts as a failure.
    task automatic wait_for(input int sig, input int limit, input string name, output int c);
        c = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sig_now(sig)) begin
                c = cyc;
                return;
            end
        end
        n_checks++;
        $display("FAIL wait_%s: no event within %0d cycles (cycle %0d)", name, limit, cyc);
    endtask

    // SCCB model A: ready drops 2 cycles after start, rises 40 cycles later.
    initial begin
        int ph = 0;
        int cnt = 0;
        ready_a = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                ph = 0; cnt = 0; ready_a = 1'b1;
            end else begin
                case (ph)
                    0: begin
                        ready_a = !hold_a;
                        if (sccb_start_a) begin ph = 1; cnt = 0; end
                    end
                    1: begin
                        cnt++;
                        if (cnt == 2) begin ready_a = 1'b0; ph = 2; cnt = 0; end
                    end
                    default: begin
                        cnt++;
                        if (cnt == 40) begin ready_a = 1'b1; rise_cyc_a = cyc; ph = 0; end
                    end
                endcase
            end
        end
    end

    // SCCB model B: drop 2 after start, rise 5 later; no_drop_b never accepts.
    initial begin
        int ph = 0;
        int cnt = 0;
        ready_b = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                ph = 0; cnt = 0; ready_b = 1'b1;
            end else begin
                case (ph)
                    0: begin
                        ready_b = 1'b1;
                        if (sccb_start_b) begin ph = 1; cnt = 0; end
                    end
                    1: begin
                        cnt++;
                        if (no_drop_b) ph = 0;
                        else if (cnt == 2) begin ready_b = 1'b0; ph = 2; cnt = 0; end
                    end
                    default: begin
                        cnt++;
                        if (cnt == 5) begin ready_b = 1'b1; ph = 0; end
                    end
                endcase
            end
        end
    end

    // Scoreboard for instance A plus per-cycle grant/err invariants.
    always @(negedge clk) begin
        if (!rst) begin
            check("grant_a_onehot0", 32'($onehot0(grant_a)), 32'd1);
            check("grant_b_onehot0", 32'($onehot0(grant_b)), 32'd1);
            if (sccb_start_a) begin
                if (q_a.size() == 0) begin
                    check("unexpected_start_a", 32'd1, 32'd0);
                end else begin
                    cur_a = q_a.pop_front();
                    check("start_grant_a", 32'(grant_a), 32'(cur_a.g));
                    check("start_addr_a", 32'(sccb_addr_a), 32'(cur_a.a));
                    check("start_data_a", 32'(sccb_data_a), 32'(cur_a.d));
                end
            end
            if (done_a != 2'b00) begin
                check("done_bit_a", 32'(done_a), 32'(cur_a.g));
                check("err_bit_a", 32'(err_a), cur_a.e ? 32'(cur_a.g) : 32'd0);
                check("addr_hold_a", 32'(sccb_addr_a), 32'(cur_a.a));
                check("data_hold_a", 32'(sccb_data_a), 32'(cur_a.d));
            end else begin
                check("err_without_done_a", 32'(err_a), 32'd0);
            end
        end
    end

    // Present a request on A (called at a negedge) and queue its expected grant.
    task automatic start_txn_a(input logic [1:0] r, input logic [7:0] a0, input logic [7:0] d0,
                               input logic [7:0] a1, input logic [7:0] d1, input int idx,
                               output int drv_c);
        exp_t e;
        req_addr_a = {a1, a0};
        req_data_a = {d1, d0};
        req_a      = r;
        e.g = 2'(1 << idx);
        e.a = (idx == 1) ? a1 : a0;
        e.d = (idx == 1) ? d1 : d0;
        e.e = 1'b0;
        q_a.push_back(e);
        drv_c = cyc;
    endtask

    // Follow one A write to completion: start latency, done timing, single pulse.
    task automatic finish_txn_a(input int exp_start);
        int sc, dc, ic;
        wait_for(SIG_START_A, 50, "start_a", sc);
        check("start_latency_a", 32'(sc), 32'(exp_start));
        req_addr_a = ~req_addr_a;
        req_data_a = ~req_data_a;
        wait_for(SIG_DONE_A, 200, "done_a", dc);
        check("done_after_ready_a", 32'(dc), 32'(rise_cyc_a + 1));
        req_a = 2'b00;
        @(negedge clk);
        check("done_single_cycle_a", 32'(done_a), 32'd0);
        check("grant_clear_settle_a", 32'(grant_a), 32'd0);
        wait_for(SIG_IDLE_A, 60, "idle_a", ic);
    endtask

    initial begin
        int drv, sc, dc, ic, prev_dc, eidx;
        rst = 1'b1;
        req_a = '0; req_addr_a = '0; req_data_a = '0;
        req_b = '0; req_addr_b = '0; req_data_b = '0;

        tbl[0] = '{2'b01, 8'h12, 8'h80, 8'h00, 8'h00, 0};
        tbl[1] = '{2'b10, 8'h00, 8'h00, 8'h3A, 8'h04, 1};
        tbl[2] = '{2'b11, 8'h55, 8'hAA, 8'h0F, 8'hF0, 0};
        tbl[3] = '{2'b11, 8'h01, 8'h02, 8'hFE, 8'hFD, 1};
        tbl[4] = '{2'b10, 8'h11, 8'h22, 8'h00, 8'hFF, 1};
        tbl[5] = '{2'b11, 8'h7E, 8'h81, 8'hC3, 8'h3C, 0};
        tbl[6] = '{2'b01, 8'hFF, 8'h00, 8'h99, 8'h98, 0};
        tbl[7] = '{2'b11, 8'h6B, 8'h6C, 8'h93, 8'h94, 1};

        repeat (3) @(negedge clk);
        check("rst_grant_a", 32'(grant_a), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_err_a", 32'(err_a), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_start_a", 32'(sccb_start_a), 32'd0);
        check("rst_addr_a", 32'(sccb_addr_a), 32'd0);
        check("rst_data_a", 32'(sccb_data_a), 32'd0);
        check("rst_grant_b", 32'(grant_b), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_rst_a", 32'(busy_a), 32'd0);

        // Single writes with a bench-tracked round-robin order.
        for (int i = 0; i < 8; i++) begin
            start_txn_a(tbl[i].req, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1, tbl[i].idx, drv);
            finish_txn_a(drv + 1);
        end

        // Both requesters held: four writes alternate 0,1,0,1 with a fixed settle gap.
        start_txn_a(2'b11, 8'h20, 8'h21, 8'h30, 8'h31, 0, drv);
        for (int k = 1; k < 4; k++) begin
            exp_t e;
            e.g = (k % 2 == 1) ? 2'b10 : 2'b01;
            e.a = (k % 2 == 1) ? 8'h30 : 8'h20;
            e.d = (k % 2 == 1) ? 8'h31 : 8'h21;
            e.e = 1'b0;
            q_a.push_back(e);
        end
        prev_dc = -1;
        for (int k = 0; k < 4; k++) begin
            wait_for(SIG_START_A, 60, "held_start_a", sc);
            if (k == 0) check("held_first_latency_a", 32'(sc), 32'(drv + 1));
            else        check("held_settle_gap_a", 32'(sc - prev_dc), 32'd17);
            wait_for(SIG_DONE_A, 200, "held_done_a", dc);
            check("held_done_after_ready_a", 32'(dc), 32'(rise_cyc_a + 1));
            if (k == 3) req_a = 2'b00;
            @(negedge clk);
            check("held_done_single_a", 32'(done_a), 32'd0);
            prev_dc = dc;
        end
        wait_for(SIG_IDLE_A, 60, "held_idle_a", ic);

        // Request while the SCCB port is not ready: no start until ready returns.
        hold_a = 1'b1;
        repeat (2) @(negedge clk);
        start_txn_a(2'b01, 8'h3C, 8'h0F, 8'h00, 8'h00, 0, drv);
        repeat (6) begin
            @(negedge clk);
            check("no_start_not_ready_a", 32'(sccb_start_a), 32'd0);
            check("no_grant_not_ready_a", 32'(grant_a), 32'd0);
        end
        hold_a = 1'b0;
        finish_txn_a(cyc + 2);

        // Reset during WAIT_DONE: outputs clear at once, no done, rr pointer back to 0.
        start_txn_a(2'b10, 8'h00, 8'h00, 8'h66, 8'h77, 1, drv);
        wait_for(SIG_START_A, 50, "rst_txn_start_a", sc);
        repeat (10) @(negedge clk);
        check("pre_rst_busy_a", 32'(busy_a), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_grant_a", 32'(grant_a), 32'd0);
        check("async_rst_busy_a", 32'(busy_a), 32'd0);
        check("async_rst_addr_a", 32'(sccb_addr_a), 32'd0);
        check("async_rst_data_a", 32'(sccb_data_a), 32'd0);
        check("async_rst_done_a", 32'(done_a), 32'd0);
        req_a = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_done_after_rst_a", 32'(done_a), 32'd0);
            check("idle_after_rst_a", 32'(busy_a), 32'd0);
        end
        start_txn_a(2'b11, 8'h0A, 8'h0B, 8'h1A, 8'h1B, 0, drv);
        finish_txn_a(drv + 1);

        // Instance B: no acceptance -> done+err 32 cycles after ISSUE.
        no_drop_b  = 1'b1;
        req_addr_b = {8'h00, 8'h00, 8'h44};
        req_data_b = {8'h00, 8'h00, 8'h55};
        req_b      = 3'b001;
        wait_for(SIG_START_B, 20, "to_start_b", sc);
        check("to_grant_b", 32'(grant_b), 32'h1);
        check("to_addr_b", 32'(sccb_addr_b), 32'h44);
        check("to_data_b", 32'(sccb_data_b), 32'h55);
        wait_for(SIG_DONE_B, 100, "to_done_b", dc);
        check("to_latency_b", 32'(dc - sc), 32'd32);
        check("to_done_b", 32'(done_b), 32'h1);
        check("to_err_b", 32'(err_b), 32'h1);
        req_b = 3'b000;
        no_drop_b = 1'b0;
        @(negedge clk);
        check("to_done_single_b", 32'(done_b), 32'd0);
        check("to_err_single_b", 32'(err_b), 32'd0);
        wait_for(SIG_IDLE_B, 20, "to_idle_b", ic);

        // rr pointer now 1: req=101 serves 2, then 0, then 2.
        req_addr_b = {8'hC2, 8'hB1, 8'hA0};
        req_data_b = {8'h2D, 8'h1D, 8'h0D};
        req_b      = 3'b101;
        for (int k = 0; k < 3; k++) begin
            eidx = (k == 1) ? 0 : 2;
            wait_for(SIG_START_B, 30, "rr_start_b", sc);
            check("rr_grant_b", 32'(grant_b), 32'(1 << eidx));
            check("rr_addr_b", 32'(sccb_addr_b), (eidx == 2) ? 32'hC2 : 32'hA0);
            check("rr_data_b", 32'(sccb_data_b), (eidx == 2) ? 32'h2D : 32'h0D);
            wait_for(SIG_DONE_B, 40, "rr_done_b", dc);
            check("rr_done_b", 32'(done_b), 32'(1 << eidx));
            check("rr_err_b", 32'(err_b), 32'd0);
            if (k == 2) req_b = 3'b000;
            @(negedge clk);
        end
        wait_for(SIG_IDLE_B, 20, "rr_idle_b", ic);

        check("scoreboard_empty_a", 32'(q_a.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
